// File: rtl/cpu_debug_cmd_sysclk_pkg.sv
// cpu_debug_pkg
//   Shared definitions for the system-clock side of the CPU debug slave.
//   - Default geometry of the JTAG shift register / IR.
//   - IR code constants selecting the action channel.
//   - Command entry struct at the default geometry.
//   - Widths of the optional timestamp and the drop counter.
//   Optional feature macro: CPU_DEBUG_CMD_TIMESTAMP_EN adds a timestamp field
//   to the entry struct.
package cpu_debug_pkg;

  localparam int unsigned DEF_SR_W   = 38;
  localparam int unsigned DEF_IR_W   = 2;

  // The MSB of the shift register selects take_action vs take_no_action.
  localparam int unsigned ACTION_BIT = DEF_SR_W - 1;

  localparam int unsigned TS_W       = 16;
  localparam int unsigned DROP_W     = 8;

  localparam logic [DEF_IR_W-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [DEF_IR_W-1:0] IR_TRACE     = 2'd1;
  localparam logic [DEF_IR_W-1:0] IR_BREAK     = 2'd2;
  localparam logic [DEF_IR_W-1:0] IR_TRACECTRL = 2'd3;

  typedef struct packed {
    logic [DEF_IR_W-1:0] ir;
    logic [DEF_SR_W-1:0] data;
`ifdef CPU_DEBUG_CMD_TIMESTAMP_EN
    logic [TS_W-1:0]     ts;
`endif
  } cmd_entry_t;

endpackage

// File: rtl/cpu_debug_cmd_sysclk_sync_edge.sv
// cpu_debug_sync_edge
//   Brings an asynchronous strobe into the clk domain and turns each rising
//   edge into a single one-cycle pulse. The pulse appears STAGES+1 cycles
//   after the first clk edge that samples the strobe high; a strobe held high
//   produces one pulse only.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   d        in   asynchronous strobe
//   pulse    out  one-cycle pulse per rising edge of d
module cpu_debug_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              lvl_q;
  logic              edge_q;
  logic              pulse_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      lvl_q   <= 1'b0;
      edge_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      // metastability chain
      sync_q  <= {sync_q[STAGES-2:0], d};
      // synchronised level, then its one-cycle-old copy for edge detection
      lvl_q   <= sync_q[STAGES-1];
      edge_q  <= lvl_q;
      // registered so the pulse leaves this block glitch-free
      pulse_q <= lvl_q & ~edge_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/cpu_debug_cmd_sysclk.sv
// cpu_debug_cmd_sysclk
//   System-clock side of the CPU debug slave. Synchronises the virtual-JTAG
//   update strobes, captures {IR, shift register} into a DEPTH-entry command
//   queue, presents the head through valid/ready, and on each pop emits a
//   one-cycle per-channel take_action / take_no_action pulse with jdo holding
//   the popped data.
// Optional feature macro: CPU_DEBUG_CMD_TIMESTAMP_EN
//   Adds a 16-bit free-running cycle counter captured per entry on push and
//   the cmd_ts output carrying the head timestamp.
// Ports:
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   ir_in          in   JTAG IR (quasi-static, tck domain)
//   sr             in   JTAG shift register (stable while vs_udr high)
//   vs_uir/vs_udr  in   update-IR / update-DR strobes (tck domain)
//   cmd_valid      out  queue head valid
//   cmd_ready      in   consumer accepts head
//   cmd_ir         out  IR of head entry
//   cmd_data       out  data of head entry
//   cmd_ts         out  head timestamp (timestamp build only)
//   jdo            out  data of last popped command
//   take_action    out  one-hot pulse on pop, action bit set
//   take_no_action out  one-hot pulse on pop, action bit clear
//   ovf            out  sticky queue overflow
//   ill_ir         out  sticky illegal IR
//   drop_cnt       out  dropped-command count, saturating
//   flag_clr       in   clears ovf, ill_ir, drop_cnt
module cpu_debug_cmd_sysclk
  import cpu_debug_pkg::*;
#(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int N_CH        = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [SR_W-1:0]   sr,
  input  logic              vs_uir,
  input  logic              vs_udr,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [IR_W-1:0]   cmd_ir,
  output logic [SR_W-1:0]   cmd_data,
`ifdef CPU_DEBUG_CMD_TIMESTAMP_EN
  output logic [TS_W-1:0]   cmd_ts,
`endif
  output logic [SR_W-1:0]   jdo,
  output logic [N_CH-1:0]   take_action,
  output logic [N_CH-1:0]   take_no_action,
  output logic              ovf,
  output logic              ill_ir,
  output logic [DROP_W-1:0] drop_cnt,
  input  logic              flag_clr
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW:0]     PTR_ONE = (AW+1)'(1);
  localparam logic [IR_W:0]   N_CH_V  = (IR_W+1)'(N_CH);

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] data;
`ifdef CPU_DEBUG_CMD_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
`endif
  } entry_t;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  logic uir_p;
  logic udr_p;

  cpu_debug_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_uir (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (vs_uir),
    .pulse   (uir_p)
  );

  cpu_debug_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_udr (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (vs_udr),
    .pulse   (udr_p)
  );

  // IR capture. A same-cycle udr_p still sees the old value because the
  // push below reads ir_q, which only updates at the end of this cycle.
  logic [IR_W-1:0] ir_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q <= '0;
    end else if (uir_p) begin
      ir_q <= ir_in;
    end
  end

`ifdef CPU_DEBUG_CMD_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
    end
  end
`endif

  // Queue bookkeeping: pointers carry one wrap bit above the index so that
  // equal indices distinguish full (wrap bits differ) from empty.
  entry_t      mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        ir_legal;
  logic        push_req;
  logic        push_ok;
  logic        drop_full;
  logic        drop_ill;
  logic        drop_ev;
  entry_t      wr_entry;
  entry_t      head;

  assign ir_legal  = ({1'b0, ir_q} < N_CH_V);
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_valid = ~empty;
  assign pop       = cmd_valid & cmd_ready;
  assign push_req  = udr_p & ir_legal;
  // A pop in the same cycle frees the slot the push is about to fill.
  assign push_ok   = push_req & (~full | pop);
  assign drop_full = push_req & full & ~pop;
  assign drop_ill  = udr_p & ~ir_legal;
  assign drop_ev   = drop_full | drop_ill;

  always_comb begin
    wr_entry      = '0;
    wr_entry.ir   = ir_q;
    wr_entry.data = sr;
`ifdef CPU_DEBUG_CMD_TIMESTAMP_EN
    wr_entry.ts   = ts_cnt;
`endif
  end

  // Entry storage carries no reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Head slot is never written while it is the head, so these are stable
  // for as long as cmd_valid is held.
  assign head     = mem[rd_ptr[AW-1:0]];
  assign cmd_ir   = head.ir;
  assign cmd_data = head.data;
`ifdef CPU_DEBUG_CMD_TIMESTAMP_EN
  assign cmd_ts   = head.ts;
`endif

  logic [N_CH-1:0] sel_oh;

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel_oh[i] = (cmd_ir == IR_W'(i));
    end
  end

  // ---- pop stage: registered decode of the popped head ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= (pop &&  cmd_data[SR_W-1]) ? sel_oh : '0;
      take_no_action <= (pop && !cmd_data[SR_W-1]) ? sel_oh : '0;
      if (pop) begin
        jdo <= cmd_data;
      end
    end
  end

  // Sticky status. A drop in the same cycle as flag_clr wins, leaving the
  // flag set and the count at one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf      <= 1'b0;
      ill_ir   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drop_full) begin
        ovf <= 1'b1;
      end else if (flag_clr) begin
        ovf <= 1'b0;
      end

      if (drop_ill) begin
        ill_ir <= 1'b1;
      end else if (flag_clr) begin
        ill_ir <= 1'b0;
      end

      if (drop_ev) begin
        drop_cnt <= flag_clr ? DROP_W'(1) : sat_inc(drop_cnt);
      end else if (flag_clr) begin
        drop_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_debug_cmd_sysclk.sv
module tb_cpu_debug_cmd_sysclk;

  localparam int SR_W        = 38;
  localparam int IR_W        = 2;
  localparam int N_CH        = 3;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [IR_W-1:0]   ir_in;
  logic [SR_W-1:0]   sr;
  logic              vs_uir;
  logic              vs_udr;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [IR_W-1:0]   cmd_ir;
  logic [SR_W-1:0]   cmd_data;
`ifdef CPU_DEBUG_CMD_TIMESTAMP_EN
  logic [15:0]       cmd_ts;
`endif
  logic [SR_W-1:0]   jdo;
  logic [N_CH-1:0]   take_action;
  logic [N_CH-1:0]   take_no_action;
  logic              ovf;
  logic              ill_ir;
  logic [7:0]        drop_cnt;
  logic              flag_clr;

  always #5 clk = ~clk;

  cpu_debug_cmd_sysclk #(
    .SR_W(SR_W), .IR_W(IR_W), .N_CH(N_CH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
    .vs_uir(vs_uir), .vs_udr(vs_udr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
`ifdef CPU_DEBUG_CMD_TIMESTAMP_EN
    .cmd_ts(cmd_ts),
`endif
    .jdo(jdo), .take_action(take_action), .take_no_action(take_no_action),
    .ovf(ovf), .ill_ir(ill_ir), .drop_cnt(drop_cnt), .flag_clr(flag_clr)
  );

  // Reference model: a queue of accepted commands plus the status the rules
  // imply, updated once per strobe transaction.
  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] data;
  } ent_t;

  ent_t mq[$];
  int   m_ir;
  bit   m_ovf;
  bit   m_ill;
  int   m_drop;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int sat_add1(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  function automatic void model_udr(input logic [SR_W-1:0] d);
    ent_t e;
    if (m_ir >= N_CH) begin
      m_ill  = 1'b1;
      m_drop = sat_add1(m_drop);
    end else if (mq.size() >= DEPTH) begin
      m_ovf  = 1'b1;
      m_drop = sat_add1(m_drop);
    end else begin
      e.ir   = IR_W'(m_ir);
      e.data = d;
      mq.push_back(e);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ir = 0; m_ovf = 1'b0; m_ill = 1'b0; m_drop = 0;
  endfunction

  function automatic logic [SR_W-1:0] rnd_data();
    return SR_W'({$urandom(), $urandom()}) | SR_W'(1);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_uir(input int ir);
    tick();
    ir_in = IR_W'(ir); vs_uir = 1'b1;
    repeat (2) tick();
    vs_uir = 1'b0;
    repeat (6) tick();
    m_ir = ir;
  endtask

  task automatic pulse_udr(input logic [SR_W-1:0] d);
    tick();
    sr = d; vs_udr = 1'b1;
    repeat (2) tick();
    vs_udr = 1'b0;
    repeat (6) tick();
    model_udr(d);
  endtask

  task automatic check_status(input string tag);
    n_cmp++;
    if (ovf !== m_ovf) begin n_bad++; $display("FAIL %s_ovf got %b want %b", tag, ovf, m_ovf); end
    n_cmp++;
    if (ill_ir !== m_ill) begin n_bad++; $display("FAIL %s_ill_ir got %b want %b", tag, ill_ir, m_ill); end
    n_cmp++;
    if (drop_cnt !== 8'(m_drop)) begin n_bad++; $display("FAIL %s_drop_cnt got %0d want %0d", tag, drop_cnt, m_drop); end
  endtask

  task automatic clear_flags();
    tick();
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    m_ovf = 1'b0; m_ill = 1'b0; m_drop = 0;
    check_status("flag_clr");
  endtask

  // Pops the whole model queue with cmd_ready held, checking the head at
  // each negedge and the pulses/jdo the previous pop produced.
  task automatic drain_all(input string tag);
    ent_t prev;
    bit have_prev;
    logic [N_CH-1:0] exp_ta, exp_tn;
    have_prev = 1'b0;
    prev = '0;
    @(negedge clk);
    cmd_ready = 1'b1;
    for (int g = 0; g < DEPTH + 4; g++) begin
      exp_ta = '0; exp_tn = '0;
      if (have_prev) begin
        if (prev.data[SR_W-1]) exp_ta = N_CH'(1) << prev.ir;
        else                   exp_tn = N_CH'(1) << prev.ir;
        n_cmp++;
        if (jdo !== prev.data) begin n_bad++; $display("FAIL %s_jdo got %h want %h", tag, jdo, prev.data); end
      end
      n_cmp++;
      if (take_action !== exp_ta || take_no_action !== exp_tn) begin
        n_bad++;
        $display("FAIL %s_pulses got ta=%b tn=%b want ta=%b tn=%b", tag, take_action, take_no_action, exp_ta, exp_tn);
      end
      if (mq.size() == 0) begin
        n_cmp++;
        if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL %s_empty got valid=%b want 0", tag, cmd_valid); end
        break;
      end
      n_cmp++;
      if (cmd_valid !== 1'b1 || {cmd_ir, cmd_data} !== mq[0]) begin
        n_bad++;
        $display("FAIL %s_head got v=%b ir=%0d data=%h want ir=%0d data=%h", tag, cmd_valid, cmd_ir, cmd_data, mq[0].ir, mq[0].data);
      end
      prev = mq.pop_front();
      have_prev = 1'b1;
      @(negedge clk);
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ir_in = '0; sr = '0; vs_uir = 1'b0; vs_udr = 1'b0;
    cmd_ready = 1'b0; flag_clr = 1'b0;
    model_reset();
    repeat (3) tick();
    n_cmp++;
    if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
    n_cmp++;
    if (jdo !== '0) begin n_bad++; $display("FAIL reset_jdo got %h want 0", jdo); end
    n_cmp++;
    if (take_action !== '0 || take_no_action !== '0) begin
      n_bad++; $display("FAIL reset_pulses got %b/%b want 0/0", take_action, take_no_action);
    end
    check_status("reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    logic [SR_W-1:0] d;
    bit early;
    pulse_uir(2);
    cmd_ready = 1'b1;
    d = {1'b1, 37'h5A};
    tick();
    sr = d; vs_udr = 1'b1;
    tick();  // just after the first sampling edge
    early = 1'b0;
    repeat (3) begin tick(); if (cmd_valid !== 1'b0) early = 1'b1; end
    n_cmp++;
    if (early) begin n_bad++; $display("FAIL basic_latency got valid before 4 cycles want 4"); end
    tick();
    n_cmp++;
    if (cmd_valid !== 1'b1 || cmd_ir !== 2'd2 || cmd_data !== d) begin
      n_bad++; $display("FAIL basic_head got v=%b ir=%0d data=%h want 1/2/%h", cmd_valid, cmd_ir, cmd_data, d);
    end
    tick();
    n_cmp++;
    if (jdo !== 38'h20_0000_005A) begin n_bad++; $display("FAIL basic_jdo got %h want 200000005a", jdo); end
    n_cmp++;
    if (take_action !== 3'b100 || take_no_action !== 3'b000) begin
      n_bad++; $display("FAIL basic_pulse got ta=%b tn=%b want 100/000", take_action, take_no_action);
    end
    tick();
    n_cmp++;
    if (take_action !== 3'b000 || cmd_valid !== 1'b0 || jdo !== 38'h20_0000_005A) begin
      n_bad++; $display("FAIL basic_pulse_width got ta=%b v=%b jdo=%h want 000/0/held", take_action, cmd_valid, jdo);
    end
    vs_udr = 1'b0; cmd_ready = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_overflow();
    pulse_uir(1);
    for (int i = 0; i < 5; i++) pulse_udr(rnd_data());
    n_cmp++;
    if (mq.size() != DEPTH || m_ovf != 1'b1 || m_drop != 1) begin
      n_bad++; $display("FAIL ovf_model_sanity got size=%0d ovf=%b drop=%0d want 4/1/1", mq.size(), m_ovf, m_drop);
    end
    check_status("overflow");
    drain_all("overflow");
    clear_flags();
  endtask

  task automatic test_full_simul();
    logic [SR_W-1:0] d;
    ent_t popped, pushed;
    pulse_uir(0);
    for (int i = 0; i < DEPTH; i++) pulse_udr(rnd_data());
    d = rnd_data();
    tick();
    sr = d; vs_udr = 1'b1;
    tick();                  // first sampling edge
    repeat (3) tick();       // the internal pulse is now active
    cmd_ready = 1'b1;
    tick();                  // pop and push on the same edge
    cmd_ready = 1'b0; vs_udr = 1'b0;
    popped = mq.pop_front();
    pushed.ir = IR_W'(m_ir); pushed.data = d;
    mq.push_back(pushed);
    n_cmp++;
    if (jdo !== popped.data) begin n_bad++; $display("FAIL simul_jdo got %h want %h", jdo, popped.data); end
    check_status("simul");
    repeat (6) tick();
    drain_all("simul");
  endtask

  task automatic test_illegal();
    pulse_uir(3);
    pulse_udr(rnd_data());
    n_cmp++;
    if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL illegal_no_push got valid=%b want 0", cmd_valid); end
    check_status("illegal");
    clear_flags();
    pulse_udr(rnd_data());
    pulse_udr(rnd_data());
    check_status("illegal_two");
    // flag_clr coincident with a drop
    tick();
    sr = rnd_data(); vs_udr = 1'b1;
    tick();
    repeat (3) tick();
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0; vs_udr = 1'b0;
    m_ill = 1'b1; m_drop = 1;
    check_status("clr_vs_drop");
    repeat (6) tick();
    for (int i = 0; i < 258; i++) pulse_udr(rnd_data());
    check_status("saturate");
    clear_flags();
  endtask

  task automatic test_held_and_reset();
    logic [SR_W-1:0] d;
    bit spurious;
    pulse_uir(2);
    d = rnd_data();
    tick();
    sr = d; vs_udr = 1'b1;
    repeat (20) tick();
    vs_udr = 1'b0;
    repeat (6) tick();
    model_udr(d);
    drain_all("held");
    pulse_udr(rnd_data());
    pulse_udr(rnd_data());
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (cmd_valid !== 1'b0 || jdo !== '0 || take_action !== '0 || take_no_action !== '0) begin
      n_bad++; $display("FAIL async_reset got v=%b jdo=%h ta=%b tn=%b want all 0", cmd_valid, jdo, take_action, take_no_action);
    end
    check_status("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    spurious = 1'b0;
    repeat (12) begin
      tick();
      if (cmd_valid !== 1'b0 || take_action !== '0 || take_no_action !== '0) spurious = 1'b1;
    end
    n_cmp++;
    if (spurious) begin n_bad++; $display("FAIL post_reset_quiet got activity want none"); end
    // ir_q must be back at 0 after reset
    pulse_udr(rnd_data());
    drain_all("post_reset");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      pulse_uir($urandom_range(0, N_CH - 1));
      for (int k = 0, n = $urandom_range(1, DEPTH + 1); k < n; k++) pulse_udr(rnd_data());
      check_status("random");
      drain_all("random");
      clear_flags();
    end
  endtask

`ifdef CPU_DEBUG_CMD_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [15:0] ts1, ts2;
    logic [SR_W-1:0] d1, d2;
    pulse_uir(1);
    d1 = rnd_data(); d2 = rnd_data();
    tick();
    sr = d1; vs_udr = 1'b1;
    repeat (2) tick();
    vs_udr = 1'b0;
    repeat (8) tick();
    sr = d2; vs_udr = 1'b1;
    repeat (2) tick();
    vs_udr = 1'b0;
    repeat (6) tick();
    model_udr(d1); model_udr(d2);
    @(negedge clk);
    ts1 = cmd_ts;
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    ts2 = cmd_ts;
    void'(mq.pop_front());
    n_cmp++;
    if (16'(ts2 - ts1) !== 16'd10) begin n_bad++; $display("FAIL ts_delta got %0d want 10", 16'(ts2 - ts1)); end
    drain_all("timestamp");
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_simul();
    test_illegal();
    test_held_and_reset();
    test_random();
`ifdef CPU_DEBUG_CMD_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
